// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register file write port.
// The arbiter uses the slave modport. The sources and the register file side use the master modport.
interface regfile_wb_arbiter_if;
    logic        alu_vld_w_i;
    logic [4:0]  alu_reg_w_i;
    logic [31:0] alu_data_w_i;
    logic        alu_rdy_w_o;

    logic        mem_vld_w_i;
    logic [4:0]  mem_reg_w_i;
    logic [31:0] mem_data_w_i;
    logic        mem_rdy_w_o;

    logic [4:0]  wr_reg_w_o;
    logic [31:0] wr_data_w_o;
    logic        reg_wr_flag_w_o;
    logic        starved_w_o;

    modport slave (
        input  alu_vld_w_i, alu_reg_w_i, alu_data_w_i,
        input  mem_vld_w_i, mem_reg_w_i, mem_data_w_i,
        output alu_rdy_w_o, mem_rdy_w_o,
        output wr_reg_w_o, wr_data_w_o, reg_wr_flag_w_o, starved_w_o
    );

    modport master (
        output alu_vld_w_i, alu_reg_w_i, alu_data_w_i,
        output mem_vld_w_i, mem_reg_w_i, mem_data_w_i,
        input  alu_rdy_w_o, mem_rdy_w_o,
        input  wr_reg_w_o, wr_data_w_o, reg_wr_flag_w_o, starved_w_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source register file writeback arbiter: MEM has priority, and a starvation counter eventually forces an ALU grant.
// Defining REGFILE_WB_X0_DROP_EN suppresses write strobes to register 0.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic                  clk_w_i,
    input logic                  res_w_i_h,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic        at_limit;
    logic        alu_grant;
    logic        mem_grant;
    logic        write_en;
    logic [4:0]  grant_reg;
    logic [31:0] grant_data;

    // MEM wins a tie unless ALU has already waited STARVE_LIMIT grants.
    always_comb begin
        at_limit   = (starve_cnt >= LIMIT);
        alu_grant  = 1'b0;
        mem_grant  = 1'b0;
        grant_reg  = bus.mem_reg_w_i;
        grant_data = bus.mem_data_w_i;
        if (!res_w_i_h) begin
            alu_grant = bus.alu_vld_w_i && (!bus.mem_vld_w_i || at_limit);
            mem_grant = bus.mem_vld_w_i && !(bus.alu_vld_w_i && at_limit);
        end
        if (alu_grant) begin
            grant_reg  = bus.alu_reg_w_i;
            grant_data = bus.alu_data_w_i;
        end
`ifdef REGFILE_WB_X0_DROP_EN
        write_en = (alu_grant || mem_grant) && (grant_reg != 5'd0);
`else
        write_en = alu_grant || mem_grant;
`endif
    end

    assign bus.alu_rdy_w_o = alu_grant;
    assign bus.mem_rdy_w_o = mem_grant;
    assign bus.starved_w_o = at_limit;

    always_ff @(posedge clk_w_i) begin
        if (res_w_i_h) begin
            starve_cnt <= 4'd0;
        end else if (!bus.alu_vld_w_i || alu_grant) begin
            starve_cnt <= 4'd0;
        end else if (mem_grant && !at_limit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A consumed but dropped transfer leaves the previous index and data on the port.
    always_ff @(posedge clk_w_i) begin
        if (res_w_i_h) begin
            bus.wr_reg_w_o      <= 5'd0;
            bus.wr_data_w_o     <= 32'd0;
            bus.reg_wr_flag_w_o <= 1'b0;
        end else begin
            bus.reg_wr_flag_w_o <= write_en;
            if (write_en) begin
                bus.wr_reg_w_o  <= grant_reg;
                bus.wr_data_w_o <= grant_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-sequence bench for regfile_wb_arbiter. A behavioural model predicts each cycle's grants.
// It queues the write expected one cycle later.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic        flag;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_wb_arbiter_if bus();

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    int          mCnt  = 0;
    logic [4:0]  mReg  = 5'd0;
    logic [31:0] mData = 32'd0;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_w_i   (clk),
        .res_w_i_h (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at the falling edge, check grants, model the edge, check the registered write.
    task automatic applyStimulus(input logic r,
                                 input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        logic expAlu;
        logic expMem;
        logic flag;
        logic drop;
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.alu_vld_w_i  = av;
        bus.alu_reg_w_i  = ar;
        bus.alu_data_w_i = ad;
        bus.mem_vld_w_i  = mv;
        bus.mem_reg_w_i  = mr;
        bus.mem_data_w_i = md;
        #1;
        expAlu = 1'b0;
        expMem = 1'b0;
        if (!r) begin
            if (av && mv) begin
                if (mCnt == LIMIT) expAlu = 1'b1;
                else               expMem = 1'b1;
            end else begin
                expAlu = av;
                expMem = mv;
            end
        end
        checkOutput("alu_rdy", 32'(bus.alu_rdy_w_o), 32'(expAlu));
        checkOutput("mem_rdy", 32'(bus.mem_rdy_w_o), 32'(expMem));
        if (!r) checkOutput("starved", 32'(bus.starved_w_o), 32'(mCnt == LIMIT));

        flag = 1'b0;
        if (r) begin
            mCnt  = 0;
            mReg  = 5'd0;
            mData = 32'd0;
        end else begin
            if (!av || expAlu)            mCnt = 0;
            else if (expMem && mCnt < LIMIT) mCnt = mCnt + 1;
            if (expAlu || expMem) begin
`ifdef REGFILE_WB_X0_DROP_EN
                drop = ((expAlu ? ar : mr) == 5'd0);
`else
                drop = 1'b0;
`endif
                if (!drop) begin
                    flag  = 1'b1;
                    mReg  = expAlu ? ar : mr;
                    mData = expAlu ? ad : md;
                end
            end
        end
        expQ.push_back('{flag: flag, wreg: mReg, wdata: mData});

        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = expQ.pop_front();
            checkOutput("wr_flag", 32'(bus.reg_wr_flag_w_o), 32'(e.flag));
            checkOutput("wr_reg",  32'(bus.wr_reg_w_o),      32'(e.wreg));
            checkOutput("wr_data", bus.wr_data_w_o,          e.wdata);
        end
    endtask

    initial begin
        bus.alu_vld_w_i  = 1'b0;
        bus.alu_reg_w_i  = 5'd0;
        bus.alu_data_w_i = 32'd0;
        bus.mem_vld_w_i  = 1'b0;
        bus.mem_reg_w_i  = 5'd0;
        bus.mem_data_w_i = 32'd0;

        $display("[TB] reset");
        applyStimulus(1, 1, 5'd9, 32'h11, 1, 5'd10, 32'h22);
        applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] single ALU write");
        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] starvation sequence");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 5'd1, 32'h1000 + 32'(i), 1, 5'd2, 32'h2000 + 32'(i));
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] counter clears when ALU idles");
        applyStimulus(0, 1, 5'd3, 32'h31, 1, 5'd4, 32'h41);
        applyStimulus(0, 1, 5'd3, 32'h32, 1, 5'd4, 32'h42);
        applyStimulus(0, 0, 5'd3, 32'h33, 1, 5'd4, 32'h43);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 5'd3, 32'h50 + 32'(i), 1, 5'd4, 32'h60 + 32'(i));
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] same register collision");
        applyStimulus(0, 1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        applyStimulus(0, 1, 5'd7, 32'h1, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 5'd11, 32'hA0 + 32'(i), 1, 5'd12, 32'hB0 + 32'(i));
        applyStimulus(1, 1, 5'd11, 32'hA3, 1, 5'd12, 32'hB3);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 5'd11, 32'hC0 + 32'(i), 1, 5'd12, 32'hD0 + 32'(i));
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] register 0 write");
        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h55);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("[TB] back-to-back ALU writes");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 5'(20 + i), 32'hF00 + 32'(i), 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
